ram_output_ctrl: RTL and testbench

Arbiter and sequencer for the 16x8 output-layer RAM. The RAM has a registered read address, so q is valid the cycle after the address is presented. Three clients share the RAM port:
- the output-layer compute engine (writes);
- the host/readout logic (random reads);
- an internal argmax scan that reads entries 0..NUM_OUT-1 and reports the index and value of the largest entry (the classified digit).

---
 rtl/ram_output_ctrl.sv | 131 +++++++++++++
 tb/tb_ram_output_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_output_ctrl.sv
// ram_output_ctrl: port arbiter and argmax sequencer for the output-layer RAM.
// Clients: compute-engine writes, host reads, and an internal scan that finds
// the largest of entries 0..NUM_OUT-1. RAM read data arrives one cycle after
// the address, so every compare works on the address issued the cycle before.
module ram_output_ctrl #(
  parameter int NUM_OUT = 10,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              scan_start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] max_idx,
  output logic [DATA_W-1:0] max_val,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] LAST = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [ADDR_W-1:0] END_ADDR = ADDR_W'(NUM_OUT - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] cnt;
  // cmp_valid/cmp_idx describe what ram_q holds this cycle (address issued last cycle)
  logic              cmp_valid;
  logic [ADDR_W-1:0] cmp_idx;
  logic [ADDR_W-1:0] run_idx;
  logic [DATA_W-1:0] run_val;
  logic              take;
  logic [ADDR_W-1:0] nxt_idx;
  logic [DATA_W-1:0] nxt_val;

  assign busy    = (state == SCAN) || (state == LAST);
  assign done    = (state == DONE);
  assign rd_data = ram_q;

  // RAM port arbitration: scan owns the port while busy, then write, then read
  always_comb begin
    wr_gnt   = 1'b0;
    rd_gnt   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_data = '0;
    if (state == SCAN) begin
      ram_addr = cnt;
    end else if (state == LAST) begin
      ram_addr = '0;
    end else if (wr_req) begin
      wr_gnt   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = wr_addr;
      ram_data = wr_data;
    end else if (rd_req) begin
      rd_gnt   = 1'b1;
      ram_addr = rd_addr;
    end
  end

  // Running-max update: entry 0 always seeds, later entries need strictly greater
  always_comb begin
    take    = cmp_valid && ((cmp_idx == '0) || (ram_q > run_val));
    nxt_idx = take ? cmp_idx : run_idx;
    nxt_val = take ? ram_q   : run_val;
  end

  // Scan sequencer, compare pipeline and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cmp_valid <= 1'b0;
      cmp_idx   <= '0;
      run_idx   <= '0;
      run_val   <= '0;
      max_idx   <= '0;
      max_val   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid  <= rd_gnt;
      cmp_valid <= (state == SCAN);
      cmp_idx   <= cnt;
      run_idx   <= nxt_idx;
      run_val   <= nxt_val;
      case (state)
        IDLE: begin
          if (scan_start) begin
            state <= SCAN;
            cnt   <= '0;
          end
        end
        SCAN: begin
          if (cnt == END_ADDR) begin
            state <= LAST;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LAST: begin
          // The final entry is compared this cycle, so publish the bypassed value
          state   <= DONE;
          max_idx <= nxt_idx;
          max_val <= nxt_val;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_output_ctrl.sv
// Self-checking bench for ram_output_ctrl with a behavioural 16x8 RAM
// (registered read address) and a read-data scoreboard.
module tb_ram_output_ctrl;

  localparam int NUM_OUT = 10;

  logic       clk;
  logic       rst;
  logic       wr_req;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_gnt;
  logic       rd_req;
  logic [3:0] rd_addr;
  logic       rd_gnt;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       scan_start;
  logic       busy;
  logic       done;
  logic [3:0] max_idx;
  logic [7:0] max_val;
  logic [7:0] ram_data;
  logic [3:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_q;

  ram_output_ctrl #(.NUM_OUT(NUM_OUT), .ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .scan_start(scan_start), .busy(busy), .done(done),
    .max_idx(max_idx), .max_val(max_val),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q)
  );

  // Behavioural RAM: write on clock, read address registered
  logic [7:0] ram_mem [16];
  logic [3:0] q_addr;
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_data;
    q_addr <= ram_addr;
  end
  assign ram_q = ram_mem[q_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // Expected RAM contents, updated only from the bench's own predicted grants
  logic [7:0] model [16];

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } rd_exp_t;
  rd_exp_t sb[$];

  typedef struct {
    logic       wr_req;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       rd_req;
    logic [3:0] ra;
    logic       e_wg;
    logic       e_rg;
    logic       e_we;
    logic [3:0] e_addr;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input logic w, input logic [3:0] wa, input logic [7:0] wd,
                               input logic r, input logic [3:0] ra,
                               input logic eg, input logic er, input logic [3:0] ea);
    vec_t v;
    v.wr_req = w; v.wa = wa; v.wd = wd; v.rd_req = r; v.ra = ra;
    v.e_wg = eg; v.e_rg = er; v.e_we = eg; v.e_addr = ea;
    return v;
  endfunction

  task automatic push_rd(input logic [3:0] a);
    rd_exp_t e;
    e.cyc  = cyc;
    e.data = model[a];
    sb.push_back(e);
  endtask

  // Read-data checker: rd_valid must appear exactly one cycle after each grant
  always @(negedge clk) begin
    if (!rst) begin
      while (sb.size() > 0 && sb[0].cyc + 1 < cyc) begin
        void'(sb.pop_front());
        chk("rd_valid_missing", 0, 1);
      end
      if (sb.size() > 0 && sb[0].cyc + 1 == cyc) begin
        rd_exp_t e;
        e = sb.pop_front();
        chk("rd_valid", {31'd0, rd_valid}, 1);
        if (rd_valid) chk("rd_data", {24'd0, rd_data}, {24'd0, e.data});
      end else if (rd_valid) begin
        chk("rd_valid_spurious", 1, 0);
      end
    end
  end

  task automatic idle_inputs();
    wr_req = 0; wr_addr = '0; wr_data = '0;
    rd_req = 0; rd_addr = '0; scan_start = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input vec_t v);
    wr_req = v.wr_req; wr_addr = v.wa; wr_data = v.wd;
    rd_req = v.rd_req; rd_addr = v.ra;
    @(negedge clk);
    chk("vec_wr_gnt", {31'd0, wr_gnt}, {31'd0, v.e_wg});
    chk("vec_rd_gnt", {31'd0, rd_gnt}, {31'd0, v.e_rg});
    chk("vec_ram_we", {31'd0, ram_we}, {31'd0, v.e_we});
    chk("vec_ram_addr", {28'd0, ram_addr}, {28'd0, v.e_addr});
    if (v.e_we) chk("vec_ram_data", {24'd0, ram_data}, {24'd0, v.wd});
    if (v.e_wg) model[v.wa] = v.wd;
    if (v.e_rg) push_rd(v.ra);
    next_cycle();
    idle_inputs();
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    apply_vec(mkv(1, a, d, 0, 4'd0, 1, 0, a));
  endtask

  task automatic do_read(input logic [3:0] a);
    apply_vec(mkv(0, 4'd0, 8'd0, 1, a, 0, 1, a));
  endtask

  // Full scan with latency/busy checks; optional competing traffic and ignored starts
  task automatic run_scan(input logic [3:0] e_idx, input logic [7:0] e_val, input bit traffic);
    int  edges    = 0;
    int  busy_cnt = 0;
    bit  seen     = 0;
    scan_start = 1;
    @(negedge clk);
    chk("busy_at_start", {31'd0, busy}, 0);
    next_cycle();
    edges = 1;
    scan_start = 0;
    if (traffic) begin
      wr_req = 1; wr_addr = 4'd12; wr_data = 8'h77;
      rd_req = 1; rd_addr = 4'd12;
    end
    for (int i = 0; i < 40 && !seen; i++) begin
      scan_start = traffic && (busy_cnt == 2 || busy_cnt == NUM_OUT + 1);
      @(negedge clk);
      if (busy) begin
        busy_cnt++;
        chk("busy_no_done", {31'd0, done}, 0);
        if (traffic) begin
          chk("scan_wr_gnt", {31'd0, wr_gnt}, 0);
          chk("scan_rd_gnt", {31'd0, rd_gnt}, 0);
        end
      end
      if (done) begin
        seen = 1;
        chk("done_latency", edges, NUM_OUT + 2);
        chk("busy_cycles", busy_cnt, NUM_OUT + 1);
        chk("max_idx", {28'd0, max_idx}, {28'd0, e_idx});
        chk("max_val", {24'd0, max_val}, {24'd0, e_val});
        if (traffic) begin
          chk("done_wr_gnt", {31'd0, wr_gnt}, 1);
          chk("done_rd_gnt", {31'd0, rd_gnt}, 0);
          model[12] = 8'h77;
        end
      end
      next_cycle();
      edges++;
    end
    if (!seen) chk("done_timeout", 0, 1);
    scan_start = 0;
    wr_req = 0;
    if (traffic) begin
      @(negedge clk);
      chk("post_rd_gnt", {31'd0, rd_gnt}, 1);
      chk("post_ram_addr", {28'd0, ram_addr}, 28'd0 + 12);
      push_rd(4'd12);
      next_cycle();
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_busy", {31'd0, busy}, 0);
      chk("idle_done", {31'd0, done}, 0);
      chk("result_hold", {24'd0, max_val}, {24'd0, e_val});
      next_cycle();
    end
  endtask

  initial begin
    vec_t v;
    int   bcnt;
    int   dcnt;
    logic [7:0] init_vals [10];
    init_vals = '{8'd3, 8'd7, 8'd2, 8'd9, 8'd1, 8'd9, 8'd0, 8'd4, 8'd5, 8'd6};

    // Vectors 0..9: load test data; 10..: arbitration cases in IDLE
    for (int i = 0; i < 10; i++)
      vecs.push_back(mkv(1, 4'(i), init_vals[i], 0, 4'd0, 1, 0, 4'(i)));
    vecs.push_back(mkv(1, 4'd4,  8'hA5, 0, 4'd0,  1, 0, 4'd4));
    vecs.push_back(mkv(0, 4'd0,  8'h00, 1, 4'd4,  0, 1, 4'd4));
    vecs.push_back(mkv(0, 4'd7,  8'h00, 0, 4'd9,  0, 0, 4'd0));
    vecs.push_back(mkv(1, 4'd11, 8'h3C, 1, 4'd11, 1, 0, 4'd11));
    vecs.push_back(mkv(0, 4'd0,  8'h00, 1, 4'd11, 0, 1, 4'd11));
    vecs.push_back(mkv(0, 4'd0,  8'h00, 1, 4'd0,  0, 1, 4'd0));

    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    idle_inputs();
    rst = 1;
    #3;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 0);
    chk("rst_ram_we", {31'd0, ram_we}, 0);
    chk("rst_max_idx", {28'd0, max_idx}, 0);
    chk("rst_max_val", {24'd0, max_val}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    for (int i = 0; i < 10; i++) apply_vec(vecs[i]);
    run_scan(4'd3, 8'd9, 0);

    for (int i = 10; i < vecs.size(); i++) apply_vec(vecs[i]);

    // Entries now 3,7,2,9,A5,9,0,4,5,6: scan under competing traffic
    run_scan(4'd4, 8'hA5, 1);
    for (int i = 0; i < 10; i++) do_read(4'(i));
    do_read(4'd12);

    // Reset at the 5th busy cycle aborts the scan
    scan_start = 1;
    next_cycle();
    scan_start = 0;
    bcnt = 0;
    for (int i = 0; i < 20 && bcnt < 5; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (bcnt < 5) next_cycle();
    end
    chk("reached_busy5", bcnt, 5);
    rst = 1;
    #1;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_max_idx", {28'd0, max_idx}, 0);
    chk("abort_max_val", {24'd0, max_val}, 0);
    next_cycle();
    rst = 0;
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
      next_cycle();
    end
    chk("abort_no_done", dcnt, 0);
    run_scan(4'd4, 8'hA5, 0);

    // Single maximum at the last scanned entry, then all-equal tie
    for (int i = 0; i < 10; i++) do_write(4'(i), (i == 9) ? 8'hFF : 8'h00);
    run_scan(4'd9, 8'hFF, 0);
    for (int i = 0; i < 10; i++) do_write(4'(i), 8'h80);
    run_scan(4'd0, 8'h80, 0);

    repeat (3) next_cycle();
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
